vedic_serial_mult: RTL and testbench

- Multi-cycle OP_WIDTH x OP_WIDTH unsigned multiplier that time-shares one vedic_4x4 core.
- Sequences all nibble pairs of the operands through the core and shift-accumulates the partial products.
- Targets range x probability products in the arithmetic-encoder datapath where area matters more than throughput.
- Valid/ready handshake on the operand side and on the result side.

---
 rtl/vedic_mult_pkg.sv | 17 +
 rtl/vedic_4x4.sv | 30 +++
 rtl/vedic_serial_mult.sv | 117 +++++++++++
 tb/tb_vedic_serial_mult.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vedic_mult_pkg.sv
// Shared types and helpers for the nibble-serial vedic multiplier.
package vedic_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Bit offset of the partial product for nibble pair (i, j).
    function automatic int unsigned nib_shift(input int unsigned i, input int unsigned j);
        return NIBBLE_W * (i + j);
    endfunction

endpackage

// File: rtl/vedic_4x4.sv
// Combinational 4x4 unsigned multiplier built from four 2x2 vedic (urdhva) blocks.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] r
);

    function automatic logic [3:0] v2x2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] t;
        logic [1:0] s;
        t = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        s = {1'b0, x[1] & y[1]} + {1'b0, t[1]};
        return {s, t[0], x[0] & y[0]};
    endfunction

    logic [3:0] w_ll;
    logic [3:0] w_hl;
    logic [3:0] w_lh;
    logic [3:0] w_hh;
    logic [4:0] w_mid;

    assign w_ll  = v2x2(a[1:0], b[1:0]);
    assign w_hl  = v2x2(a[3:2], b[1:0]);
    assign w_lh  = v2x2(a[1:0], b[3:2]);
    assign w_hh  = v2x2(a[3:2], b[3:2]);
    assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};

    assign r = {w_hh, 4'b0000} + {1'b0, w_mid, 2'b00} + {4'b0000, w_ll};

endmodule

// File: rtl/vedic_serial_mult.sv
// OP_WIDTH x OP_WIDTH unsigned multiplier that walks every nibble pair through one
// vedic_4x4 core and shift-accumulates the partial products.
module vedic_serial_mult
    import vedic_mult_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   a,
    input  logic [OP_WIDTH-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*OP_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int NIB   = OP_WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int ACC_W = 2 * OP_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    generate
        if ((OP_WIDTH % 4 != 0) || (OP_WIDTH < 8)) begin : g_bad_width
            $error("vedic_serial_mult: OP_WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next;
    logic [OP_WIDTH-1:0] r_a;
    logic [OP_WIDTH-1:0] r_b;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_i;
    logic [CNT_W-1:0]    r_j;
    logic [3:0]          w_a_nib;
    logic [3:0]          w_b_nib;
    logic [7:0]          w_prod;
    logic [ACC_W-1:0]    w_term;
    logic                w_last_pair;

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < NIB; k++) begin
            if (r_i == CNT_W'(k)) w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
            if (r_j == CNT_W'(k)) w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
        end
    end

    vedic_4x4 u_core (
        .a (w_a_nib),
        .b (w_b_nib),
        .r (w_prod)
    );

    assign w_term      = ACC_W'(w_prod) << nib_shift(32'(r_i), 32'(r_j));
    assign w_last_pair = (r_i == LAST) && (r_j == LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_next = MULT;
            MULT:    if (w_last_pair) w_next = DONE;
            DONE:    if (out_ready)   w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == MULT) || (r_state == DONE);
        out_valid = (r_state == DONE);
        result    = r_acc;
    end

    // acc is only cleared on acceptance so result holds its last product in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                MULT: begin
                    r_acc <= r_acc + w_term;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == LAST) ? '0 : r_i + CNT_W'(1);
                    end else begin
                        r_j <= r_j + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_serial_mult.sv
// Self-checking bench for vedic_serial_mult: directed literal cases plus randomized
// traffic against a transaction-level model (accept -> NIB*NIB cycles -> hold until taken).
module tb_vedic_serial_mult;

    localparam int W     = 16;
    localparam int NPAIR = (W / 4) * (W / 4);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [2*W-1:0] result;

    always #5 clk = ~clk;

    vedic_serial_mult #(.OP_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Transaction model: an accepted pair becomes available NPAIR edges later
    // and stays until an edge sees out_ready.
    bit          m_active = 0;
    int          m_cnt = 0;
    logic [31:0] m_exp = '0;
    int          m_done = 0;
    int          dut_hs = 0;
    bit          ov_seen = 0;

    always @(posedge clk) begin
        if (ov_seen && out_ready && !reset) dut_hs++;
        if (reset) begin
            m_active = 0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1;
                m_cnt    = 0;
                m_exp    = {16'b0, a} * {16'b0, b};
            end
        end else if (m_cnt < NPAIR) begin
            m_cnt++;
        end else if (out_ready) begin
            m_active = 0;
            m_done++;
        end
    end

    always @(negedge clk) begin
        bit exp_ov;
        exp_ov  = m_active && (m_cnt >= NPAIR);
        ov_seen = out_valid;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("busy", 32'(busy), 32'(m_active));
        chk("in_ready", 32'(in_ready), 32'(!m_active));
        if (exp_ov) chk("result", result, m_exp);
    end

    // Returns at the first negedge after the acceptance edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        a = ta;
        b = tb2;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout({nm, " accept"});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) timeout({nm, " result"});
    endtask

    task automatic finish_op(input string nm, input logic [31:0] lit, input int hold);
        for (int k = 0; k < hold; k++) begin
            chk({nm, " held result"}, result, lit);
            chk({nm, " held out_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " held in_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " pulse end"}, 32'(out_valid), 32'd0);
        chk({nm, " ready again"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic [31:0] lit, input int hold, input string nm);
        int lat;
        start_op(ta, tb2, nm);
        wait_result(nm, lat);
        chk({nm, " latency"}, 32'(lat), 32'(NPAIR));
        chk({nm, " product"}, result, lit);
        finish_op(nm, lit, hold);
    endtask

    function automatic logic [W-1:0] rand_op();
        int pick;
        pick = $urandom_range(0, 7);
        if (pick == 0) return '0;
        if (pick == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, "max");
        run_op(16'h1234, 16'h5678, 32'h06260060, 0, "mixed");
        run_op(16'h0000, 16'hABCD, 32'h00000000, 0, "zero");
        run_op(16'h0001, 16'h8000, 32'h00008000, 0, "one_msb");
        run_op(16'h00FF, 16'h0101, 32'h0000FFFF, 5, "backpressure");

        start_op(16'h0003, 16'h0005, "busy_ignore");
        repeat (3) @(negedge clk);
        a = 16'h7777;
        b = 16'h0002;
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        wait_result("busy_ignore", lat);
        chk("busy_ignore product", result, 32'h0000000F);
        finish_op("busy_ignore", 32'h0000000F, 0);
        chk("busy_ignore idle", 32'(busy), 32'd0);

        start_op(16'hABCD, 16'h1234, "reset_mid");
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid out_valid", 32'(out_valid), 32'd0);
        chk("reset_mid busy", 32'(busy), 32'd0);
        chk("reset_mid in_ready", 32'(in_ready), 32'd1);
        run_op(16'h0003, 16'h0005, 32'h0000000F, 0, "after_reset");

        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rand_op();
            b         = rand_op();
            out_ready = $urandom_range(0, 1) != 0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2 * NPAIR) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        chk("result handshakes", 32'(dut_hs), 32'(m_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
